dmg_ctrl: RTL and testbench
===========================

# dmg_ctrl

Player damage and invulnerability controller for the Jack Frost game. It takes per-monster contact flags from the collision detectors and owns the player's `health` register. It enforces a timed invulnerability window after each hit and drives the sprite blink enable for the renderer. It also raises `game_over` when health is exhausted, replacing ad-hoc health updates in the top level with one clocked state machine.

## Interface
- `MONSTER_NUM`, default 2: number of monster contact inputs.
- `HEALTH_INIT`, default 5: health after reset or restart; legal range 1..15.
- `INVULN_CYCLES`, default 300_000_000: invulnerability length in `clk` cycles (3 s at 100 MHz); must be ≥ 2.
- `BLINK_CYCLES`, default 10_000_000: blink half-period during invulnerability; must be ≥ 1.
- `clk  in  1`: system clock, 100 MHz. The whole block runs on this single clock.
- `rstn  in  1`: reset. Asynchronous and active-low.
- `hit  in  MONSTER_NUM`: level contact flags, one per monster; already gated by frozen state upstream.
- `restart  in  1`: synchronous restart request, one-cycle pulse or level.
- `pause  in  1`: freezes the block while high.
- `health  out  4`: current health.
- `invuln  out  1`: high while the invulnerability window is active.
- `sprite_vis  out  1`: player sprite enable for the renderer.
- `dmg_pulse  out  1`: one-cycle strobe on each accepted hit.
- `hit_src  out  4`: index of the monster that caused the last accepted hit.
- `game_over  out  1`: high while in DEAD.

## Operation
- States are ALIVE, INVULN and DEAD.
- Reset values: state ALIVE, `health`=HEALTH_INIT, `invuln`=0, `sprite_vis`=1, `dmg_pulse`=0, `hit_src`=0, `game_over`=0, all counters 0.
- Priority, evaluated each cycle from highest to lowest: `restart`, then `pause`, then normal operation.
- `restart` acts from any state. It sets state ALIVE and `health`=HEALTH_INIT, clears the counters and sets `sprite_vis`=1. A `hit` in the same cycle is ignored.
- `pause` holds all state, counters and outputs. `hit` is ignored and `dmg_pulse` is 0.
- **ALIVE with |`hit`=1** (hit accepted):
  - `health` decrements by 1.
  - `dmg_pulse`=1 for one cycle.
  - `hit_src` = lowest set index of `hit`.
  - Invulnerability counter loads INVULN_CYCLES-1 and the blink counter loads BLINK_CYCLES-1.
  - If the old `health` was 1: go to DEAD with `health`=0. Otherwise go to INVULN with `sprite_vis`=0.
- **INVULN**:
  - `hit` is ignored.
  - The invulnerability counter decrements every cycle.
  - The blink counter decrements; when it reaches 0 it reloads and `sprite_vis` toggles.
  - When the invulnerability counter is 0, go to ALIVE with `sprite_vis`=1.
- **DEAD**:
  - `hit` is ignored.
  - `sprite_vis`=0 and `game_over`=1.
  - The block leaves DEAD only on `restart` or reset.
- `health` never wraps below 0. `hit_src` holds its value until the next accepted hit or restart.

## Timing
- All outputs are registered.
- Hit sampled at edge N: `dmg_pulse`, `health`, `hit_src`, `invuln` and `game_over` update at edge N+1.
- `invuln` is high for exactly INVULN_CYCLES unpaused cycles. A still-asserted `hit` is accepted on the first ALIVE cycle after expiry.
- A `hit` held high across the whole window causes exactly one hit per INVULN_CYCLES+1 cycles.
- A `hit` coinciding with the expiry cycle is ignored.
- Simultaneous hits from several monsters cause one decrement only; `hit_src` takes the lowest index.
- Assertion of `rstn` mid-window clears everything immediately. Release is synchronised externally.

## Structure
- `game_pkg` holds:
  - the state enum (ALIVE, INVULN, DEAD);
  - `HEALTH_W`=4;
  - the transparent-colour constants shared with the renderer.
- Sub-module `cycle_timer`: a loadable down-counter with load, enable and `zero` flag, width derived from its max value. It is instantiated twice, once for the invulnerability counter and once for the blink counter.
- The lowest-index priority encoder is coded inline.

## Test plan
Bench parameters: HEALTH_INIT=3, INVULN_CYCLES=20, BLINK_CYCLES=4, MONSTER_NUM=2.
- Reset, then `hit`=2'b10 for 1 cycle: next cycle `health`=2, `dmg_pulse`=1, `hit_src`=1, `invuln`=1; `invuln` falls after 20 cycles.
- `hit`=2'b11 held for 60 cycles: accepted hits at cycles 1, 22 and 43; `health` reaches 0, `game_over`=1, `hit_src`=0.
- During INVULN: `sprite_vis` toggles every 4 cycles, starting at 0; `sprite_vis`=1 after expiry.
- `pause` held 10 cycles mid-window: the window extends to 30 cycles total; a `hit` during `pause` gives no pulse.
- In DEAD, `restart` with `hit`=2'b01 in the same cycle: `health`=3, state ALIVE, no `dmg_pulse`.
- `rstn` low mid-INVULN: all outputs return immediately to their reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-wide types and constants for the Jack Frost game logic.
// Used by the damage controller and the renderer-facing blocks.
package game_pkg;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    localparam int HEALTH_W = 4;

    // Sprite pixels of this colour are not drawn by the renderer.
    localparam logic [11:0] TRANSPARENT_RGB = 12'hF0F;
    localparam logic [3:0]  TRANSPARENT_IDX = 4'hF;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that reloads to MAX_VAL, holds at zero and flags it.
// Counter width is derived from MAX_VAL.
module cycle_timer #(
    parameter int MAX_VAL = 1,
    localparam int W = (MAX_VAL < 1) ? 1 : $clog2(MAX_VAL + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam logic [W-1:0] LOAD_VAL = W'(MAX_VAL);

    logic [W-1:0] count;

    assign zero = (count == '0);

    // clr beats load beats en; the counter never wraps below zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/dmg_ctrl.sv
// Player damage / invulnerability controller: owns health, the post-hit
// invulnerability window, sprite blinking and game-over.
module dmg_ctrl
    import game_pkg::*;
#(
    parameter int MONSTER_NUM   = 2,
    parameter int HEALTH_INIT   = 5,
    parameter int INVULN_CYCLES = 300_000_000,
    parameter int BLINK_CYCLES  = 10_000_000
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [MONSTER_NUM-1:0] hit,
    input  logic                   restart,
    input  logic                   pause,
    output logic [HEALTH_W-1:0]    health,
    output logic                   invuln,
    output logic                   sprite_vis,
    output logic                   dmg_pulse,
    output logic [3:0]             hit_src,
    output logic                   game_over,
    output state_t                 state
);

    state_t              state_nx;
    logic [HEALTH_W-1:0] health_nx;
    logic                sprite_nx;
    logic                pulse_nx;
    logic [3:0]          hit_src_nx;
    logic [3:0]          low_idx;
    logic                run;
    logic                accept;
    logic                inv_zero;
    logic                blink_zero;

    assign run    = !restart && !pause;
    assign accept = run && (state == ALIVE) && (|hit);

    always_comb begin
        low_idx = '0;
        for (int i = MONSTER_NUM - 1; i >= 0; i--) begin
            if (hit[i]) low_idx = 4'(i);
        end
    end

    cycle_timer #(.MAX_VAL(INVULN_CYCLES - 1)) u_inv_timer (
        .clk  (clk),
        .rstn (rstn),
        .clr  (restart),
        .load (accept),
        .en   (run && (state == INVULN)),
        .zero (inv_zero)
    );

    cycle_timer #(.MAX_VAL(BLINK_CYCLES - 1)) u_blink_timer (
        .clk  (clk),
        .rstn (rstn),
        .clr  (restart),
        .load (accept || (run && (state == INVULN) && blink_zero)),
        .en   (run && (state == INVULN)),
        .zero (blink_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ALIVE;
            health     <= HEALTH_W'(HEALTH_INIT);
            invuln     <= 1'b0;
            sprite_vis <= 1'b1;
            dmg_pulse  <= 1'b0;
            hit_src    <= '0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_nx;
            health     <= health_nx;
            invuln     <= (state_nx == INVULN);
            sprite_vis <= sprite_nx;
            dmg_pulse  <= pulse_nx;
            hit_src    <= hit_src_nx;
            game_over  <= (state_nx == DEAD);
        end
    end

    always_comb begin
        state_nx = state;
        if (restart) begin
            state_nx = ALIVE;
        end else if (!pause) begin
            case (state)
                ALIVE:   if (|hit) state_nx = (health <= HEALTH_W'(1)) ? DEAD : INVULN;
                INVULN:  if (inv_zero) state_nx = ALIVE;
                DEAD:    state_nx = DEAD;
                default: state_nx = ALIVE;
            endcase
        end
    end

    // Expiry takes precedence over a blink toggle landing on the same cycle.
    always_comb begin
        health_nx  = health;
        sprite_nx  = sprite_vis;
        pulse_nx   = 1'b0;
        hit_src_nx = hit_src;
        if (restart) begin
            health_nx  = HEALTH_W'(HEALTH_INIT);
            sprite_nx  = 1'b1;
            hit_src_nx = '0;
        end else if (!pause) begin
            case (state)
                ALIVE: begin
                    if (|hit) begin
                        health_nx  = (health == '0) ? '0 : health - 1'b1;
                        pulse_nx   = 1'b1;
                        hit_src_nx = low_idx;
                        sprite_nx  = 1'b0;
                    end
                end
                INVULN: begin
                    if (inv_zero)        sprite_nx = 1'b1;
                    else if (blink_zero) sprite_nx = !sprite_vis;
                end
                DEAD:    sprite_nx = 1'b0;
                default: sprite_nx = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_dmg_ctrl.sv
// Self-checking bench for dmg_ctrl: directed scenarios plus random traffic
// compared every cycle against a window/health model.
module tb_dmg_ctrl;
    import game_pkg::*;

    localparam int MN = 2;
    localparam int HI = 3;
    localparam int IC = 20;
    localparam int BC = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [MN-1:0] hit = '0;
    logic          restart = 1'b0;
    logic          pause = 1'b0;
    logic [3:0]    health;
    logic          invuln;
    logic          sprite_vis;
    logic          dmg_pulse;
    logic [3:0]    hit_src;
    logic          game_over;
    state_t        state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmg_ctrl #(
        .MONSTER_NUM   (MN),
        .HEALTH_INIT   (HI),
        .INVULN_CYCLES (IC),
        .BLINK_CYCLES  (BC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hit        (hit),
        .restart    (restart),
        .pause      (pause),
        .health     (health),
        .invuln     (invuln),
        .sprite_vis (sprite_vis),
        .dmg_pulse  (dmg_pulse),
        .hit_src    (hit_src),
        .game_over  (game_over),
        .state      (state)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: health count plus elapsed position inside the window.
    int         m_health;
    bit         m_dead;
    bit         m_win;
    int         m_e;
    logic [3:0] m_src;
    bit         m_pulse;
    logic [13:0] exp_q[$];
    logic [13:0] exp_v;

    function automatic int lowest(input logic [MN-1:0] h);
        logic [MN-1:0] iso;
        iso = h & (~h + 1'b1);
        return $clog2(iso);
    endfunction

    function automatic logic [13:0] model_pack();
        logic [1:0] st;
        logic       spr;
        st  = m_dead ? 2'd2 : (m_win ? 2'd1 : 2'd0);
        spr = m_dead ? 1'b0 : (m_win ? 1'(((m_e / BC) % 2)) : 1'b1);
        return {st, 4'(m_health), m_win, spr, m_pulse, m_src, m_dead};
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_health = HI; m_dead = 0; m_win = 0; m_e = 0; m_src = '0; m_pulse = 0;
            exp_q.delete();
        end else begin
            m_pulse = 0;
            if (restart) begin
                m_health = HI; m_dead = 0; m_win = 0; m_e = 0; m_src = '0;
            end else if (!pause) begin
                if (m_dead) begin
                    m_dead = 1;
                end else if (m_win) begin
                    m_e++;
                    if (m_e == IC) m_win = 0;
                end else if (hit != '0) begin
                    m_health = m_health - 1;
                    m_pulse  = 1;
                    m_src    = 4'(lowest(hit));
                    if (m_health == 0) m_dead = 1;
                    else begin m_win = 1; m_e = 0; end
                end
            end
            exp_q.push_back(model_pack());
        end
    end

    always @(negedge clk) begin
        if (rstn && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("state",      int'(state),      int'(exp_v[13:12]));
            check("health",     int'(health),     int'(exp_v[11:8]));
            check("invuln",     int'(invuln),     int'(exp_v[7]));
            check("sprite_vis", int'(sprite_vis), int'(exp_v[6]));
            check("dmg_pulse",  int'(dmg_pulse),  int'(exp_v[5]));
            check("hit_src",    int'(hit_src),    int'(exp_v[4:1]));
            check("game_over",  int'(game_over),  int'(exp_v[0]));
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_health"},    int'(health), HI);
        check({tag, "_invuln"},    int'(invuln), 0);
        check({tag, "_sprite"},    int'(sprite_vis), 1);
        check({tag, "_pulse"},     int'(dmg_pulse), 0);
        check({tag, "_src"},       int'(hit_src), 0);
        check({tag, "_game_over"}, int'(game_over), 0);
        check({tag, "_state"},     int'(state), int'(ALIVE));
    endtask

    task automatic pulse_restart(input logic [MN-1:0] h);
        @(negedge clk);
        restart = 1'b1; hit = h;
        @(negedge clk);
        restart = 1'b0; hit = '0;
    endtask

    int n;
    int pulses;
    int pulse_at[$];

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rstn = 1'b1;

        // Single hit from monster 1, then measure the window and the blink.
        @(negedge clk);
        hit = 2'b10;
        @(negedge clk);
        hit = '0;
        check("t1_health", int'(health), 2);
        check("t1_pulse",  int'(dmg_pulse), 1);
        check("t1_src",    int'(hit_src), 1);
        check("t1_invuln", int'(invuln), 1);
        n = 0;
        while (invuln && n < 100) begin
            check("t1_blink", int'(sprite_vis), (n / BC) % 2);
            n++;
            @(negedge clk);
        end
        check("t1_invuln_len", n, IC);
        check("t1_sprite_after", int'(sprite_vis), 1);

        // Pause for 10 cycles mid-window with hits asserted during the pause.
        hit = 2'b01;
        @(negedge clk);
        hit = '0;
        check("t2_health", int'(health), 1);
        n = 0; pulses = 0;
        while (invuln && n < 100) begin
            if (n == 5)  pause = 1'b1;
            if (n == 15) pause = 1'b0;
            hit = pause ? 2'b11 : 2'b00;
            if (n > 0 && dmg_pulse) pulses++;
            n++;
            @(negedge clk);
        end
        pause = 1'b0; hit = '0;
        check("t2_window_len", n, IC + 10);
        check("t2_pause_pulses", pulses, 0);

        // Held simultaneous hits from full health until death.
        pulse_restart('0);
        check("t3_restart_health", int'(health), HI);
        hit = 2'b11;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (dmg_pulse) pulse_at.push_back(c);
        end
        hit = '0;
        check("t3_pulse_count", pulse_at.size(), 3);
        if (pulse_at.size() == 3) begin
            check("t3_pulse0", pulse_at[0], 1);
            check("t3_pulse1", pulse_at[1], 22);
            check("t3_pulse2", pulse_at[2], 43);
        end
        check("t3_health",    int'(health), 0);
        check("t3_game_over", int'(game_over), 1);
        check("t3_src",       int'(hit_src), 0);
        check("t3_sprite",    int'(sprite_vis), 0);

        // Restart in DEAD with a coincident hit.
        pulse_restart(2'b01);
        check("t4_health", int'(health), HI);
        check("t4_state",  int'(state), int'(ALIVE));
        check("t4_pulse",  int'(dmg_pulse), 0);
        check("t4_game_over", int'(game_over), 0);

        // Asynchronous reset in the middle of a window.
        hit = 2'b10;
        @(negedge clk);
        hit = '0;
        repeat (5) @(negedge clk);
        check("t5_in_window", int'(invuln), 1);
        #2 rstn = 1'b0;
        #1 check_reset_values("t5_async");
        @(negedge clk);
        rstn = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            hit     = ($urandom_range(0, 9) < 3) ? MN'($urandom_range(1, 3)) : '0;
            pause   = ($urandom_range(0, 9) == 0);
            restart = ($urandom_range(0, 119) == 0);
        end
        @(negedge clk);
        hit = '0; pause = 1'b0; restart = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
